// File: rtl/vga_ball_renderer.sv
// Pixel-colour stage: bouncing ball over a red 8x8 grid, registered 4-bit RGB per pixel strobe.
// Optional macro BALL_ROUND_EN selects a round ball hit test instead of the square one.
module vga_ball_renderer #(
   parameter int H_DISPLAY = 640,
   parameter int V_DISPLAY = 480,
   parameter int B         = 10,
   parameter int SPEED     = 4,
   parameter int INIT_X    = 100,
   parameter int INIT_Y    = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_stb,
   input  logic [10:0] hpos,
   input  logic [10:0] vpos,
   input  logic        display_on,
   input  logic        enable,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic        busy
);

   localparam logic signed [11:0] X_MAX = 12'(H_DISPLAY - 1 - B);
   localparam logic signed [11:0] Y_MAX = 12'(V_DISPLAY - 1 - B);
   localparam logic signed [11:0] B_S   = 12'(B);
   localparam logic signed [11:0] NEG_B = 12'(-B);
   localparam logic signed [11:0] SPD   = 12'(SPEED);

   typedef enum logic [1:0] {IDLE, MOVE, BOUNCE} state_t;

   state_t            state;
   state_t            next_state;
   logic signed [11:0] nx;
   logic signed [11:0] ny;
   logic               x_dir;
   logic               y_dir;
   logic               frame_tick;
   logic signed [11:0] bx;
   logic signed [11:0] by;
   logic signed [11:0] dx;
   logic signed [11:0] dy;
   logic               ball_hit;

   assign frame_tick = pix_stb && (hpos == 11'd0) && (vpos == 11'(V_DISPLAY));
   assign busy       = (state != IDLE);
   assign bx         = signed'({1'b0, ball_x});
   assign by         = signed'({1'b0, ball_y});

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (frame_tick && enable) next_state = MOVE;
         MOVE:    next_state = BOUNCE;
         BOUNCE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Direction bits are 1 for increasing coordinate; each axis clamps and reflects independently.
   always_ff @(posedge clk) begin
      if (reset) begin
         ball_x <= 11'(INIT_X);
         ball_y <= 11'(INIT_Y);
         x_dir  <= 1'b1;
         y_dir  <= 1'b1;
         nx     <= '0;
         ny     <= '0;
      end else begin
         case (state)
            MOVE: begin
               nx <= x_dir ? bx + SPD : bx - SPD;
               ny <= y_dir ? by + SPD : by - SPD;
            end
            BOUNCE: begin
               if (nx > X_MAX) begin
                  ball_x <= X_MAX[10:0];
                  x_dir  <= 1'b0;
               end else if (nx < B_S) begin
                  ball_x <= B_S[10:0];
                  x_dir  <= 1'b1;
               end else begin
                  ball_x <= nx[10:0];
               end
               if (ny > Y_MAX) begin
                  ball_y <= Y_MAX[10:0];
                  y_dir  <= 1'b0;
               end else if (ny < B_S) begin
                  ball_y <= B_S[10:0];
                  y_dir  <= 1'b1;
               end else begin
                  ball_y <= ny[10:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign dx = signed'({1'b0, hpos}) - bx;
   assign dy = signed'({1'b0, vpos}) - by;

`ifdef BALL_ROUND_EN
   logic signed [23:0] dx2;
   logic signed [23:0] dy2;
   logic        [24:0] dist2;
   assign dx2      = dx * dx;
   assign dy2      = dy * dy;
   assign dist2    = 25'(unsigned'(dx2)) + 25'(unsigned'(dy2));
   assign ball_hit = dist2 < 25'(B * B);
`else
   assign ball_hit = (dx < B_S) && (dx > NEG_B) && (dy < B_S) && (dy > NEG_B);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r <= 4'h0;
         g <= 4'h0;
         b <= 4'h0;
      end else if (pix_stb) begin
         if (!display_on) begin
            r <= 4'h0;
            g <= 4'h0;
            b <= 4'h0;
         end else if (ball_hit) begin
            r <= 4'hF;
            g <= 4'hF;
            b <= 4'h0;
         end else if ((hpos[2:0] == 3'd0) || (vpos[2:0] == 3'd0)) begin
            r <= 4'hF;
            g <= 4'h0;
            b <= 4'h0;
         end else begin
            r <= 4'h0;
            g <= 4'h0;
            b <= 4'h0;
         end
      end
   end

endmodule
